alu_writeback: RTL and testbench

- Downstream stage of the 16-bit ALU. Consumes its result C, its 5-bit Flags (ZCFNL) and the 8-bit opcode that produced them.
- Maintains the architectural processor status register (PSR). Buffers register-file writes in a small in-order FIFO with a valid/ready handshake toward the register-file write port.
- Decouples ALU issue from register-file write availability.

---
 rtl/alu_writeback.sv | 96 +++++++++
 tb/tb_alu_writeback.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU writeback stage: PSR update and in-order register-file write FIFO
module alu_writeback #(
  parameter int DEPTH = 2,
  parameter int AW    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [15:0]                alu_result,
  input  logic [4:0]                 alu_flags,
  input  logic [7:0]                 alu_opcode,
  input  logic [AW-1:0]              dest,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [AW-1:0]              wb_addr,
  output logic [15:0]                wb_data,
  output logic [4:0]                 psr,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [AW-1:0] mem_addr [DEPTH];
  logic [15:0]   mem_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          is_wrf;
  logic          is_flg;
  logic          accept;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Unknown or undefined opcodes fall to default and are treated as NOPs.
  always_comb begin
    is_wrf = 1'b0;
    is_flg = 1'b0;
    case (alu_opcode[7:4])
      4'h0: begin
        is_wrf = (alu_opcode[3:0] >= 4'h1) && (alu_opcode[3:0] <= 4'h9);
        is_flg = (alu_opcode[3:0] == 4'hB) || (alu_opcode[3:0] == 4'hF);
      end
      4'h5, 4'h6, 4'h7: is_wrf = 1'b1;
      4'h8: is_wrf = (alu_opcode[3:0] == 4'h0) || (alu_opcode[3:0] == 4'h1) ||
                     (alu_opcode[3:0] == 4'h4);
      default: ;
    endcase
  end

  assign in_ready = (count < FULL);
  assign wb_valid = (count != '0);
  assign wb_addr  = mem_addr[rd_ptr];
  assign wb_data  = mem_data[rd_ptr];

  assign accept = in_valid && in_ready;
  assign push   = accept && is_wrf && !flush;
  assign pop    = wb_valid && wb_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psr    <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      // Flags commit in program order at accept, independent of flush.
      if (accept && (is_wrf || is_flg))
        psr <= alu_flags;
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          mem_addr[wr_ptr] <= dest;
          mem_data[wr_ptr] <= alu_result;
          wr_ptr           <= ptr_inc(wr_ptr);
        end
        if (pop)
          rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - directed self-checking bench for alu_writeback
module tb_alu_writeback;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] alu_result;
  logic [4:0]  alu_flags;
  logic [7:0]  alu_opcode;
  logic [3:0]  dest;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [4:0]  psr;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  alu_writeback #(.DEPTH(2), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .alu_result(alu_result), .alu_flags(alu_flags),
    .alu_opcode(alu_opcode), .dest(dest), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_data(wb_data), .psr(psr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [7:0] op, input logic [15:0] res,
                       input logic [4:0] fl, input logic [3:0] d);
    in_valid = v; alu_opcode = op; alu_result = res; alu_flags = fl; dest = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    drive(1'b0, 8'h00, 16'h0, 5'h0, 4'h0);
    repeat (3) @(negedge clk);
    checks++; if (psr !== 5'b00000) begin errors++; $display("FAIL reset_psr got %b exp 00000", psr); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if ({wb_addr, wb_data} !== 20'h0) begin errors++; $display("FAIL reset_head got %h exp 0", {wb_addr, wb_data}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({psr, wb_valid, count, in_ready} !== {5'b0, 1'b0, 2'd0, 1'b1})
      begin errors++; $display("FAIL idle_after_reset got %b exp 000000001", {psr, wb_valid, count, in_ready}); end
  endtask

  task automatic test_add_passthrough();
    wb_ready = 1'b1;
    drive(1'b1, 8'h05, 16'h1234, 5'b00100, 4'd3);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL add_wb_valid got %b exp 1", wb_valid); end
    checks++; if (wb_addr !== 4'd3) begin errors++; $display("FAIL add_wb_addr got %0d exp 3", wb_addr); end
    checks++; if (wb_data !== 16'h1234) begin errors++; $display("FAIL add_wb_data got %h exp 1234", wb_data); end
    checks++; if (psr !== 5'b00100) begin errors++; $display("FAIL add_psr got %b exp 00100", psr); end
    @(negedge clk);
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL add_count_after_pop got %0d exp 0", count); end
  endtask

  task automatic test_cmp_nop();
    drive(1'b1, 8'h0B, 16'hDEAD, 5'b00011, 4'd7);
    @(negedge clk);
    checks++; if (psr !== 5'b00011) begin errors++; $display("FAIL cmp_psr got %b exp 00011", psr); end
    checks++; if ({wb_valid, count} !== 3'b000) begin errors++; $display("FAIL cmp_no_write got %b exp 000", {wb_valid, count}); end
    drive(1'b1, 8'h00, 16'hxxxx, 5'bxxxxx, 4'd8);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (psr !== 5'b00011) begin errors++; $display("FAIL nop_psr got %b exp 00011", psr); end
    checks++; if ({wb_valid, count} !== 3'b000) begin errors++; $display("FAIL nop_no_write got %b exp 000", {wb_valid, count}); end
  endtask

  task automatic test_backpressure();
    wb_ready = 1'b0;
    drive(1'b1, 8'h01, 16'h00FF, 5'b01000, 4'd1);
    @(negedge clk);
    drive(1'b1, 8'h02, 16'h0F0F, 5'b00010, 4'd2);
    @(negedge clk);
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL full_count got %0d exp 2", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    drive(1'b1, 8'h05, 16'hAAAA, 5'b11111, 4'd7);
    @(negedge clk);
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL held_op_count got %0d exp 2", count); end
    checks++; if (psr !== 5'b00010) begin errors++; $display("FAIL held_op_psr got %b exp 00010", psr); end
    checks++; if ({wb_addr, wb_data} !== {4'd1, 16'h00FF}) begin errors++; $display("FAIL full_head got %h exp 100ff", {wb_addr, wb_data}); end
    in_valid = 1'b0; wb_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pop1_in_ready got %b exp 1", in_ready); end
    checks++; if ({count, wb_addr, wb_data} !== {2'd1, 4'd2, 16'h0F0F}) begin errors++; $display("FAIL pop1_head got %h exp 120f0f", {count, wb_addr, wb_data}); end
    @(negedge clk);
    checks++; if ({count, wb_valid} !== 3'b000) begin errors++; $display("FAIL pop2_empty got %b exp 000", {count, wb_valid}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ops [10];
    logic [19:0] q[$];
    int sent = 0, got = 0, cyc = 0;
    logic full_pred;
    ops = '{8'h01, 8'h05, 8'h50, 8'h84, 8'h09, 8'h60, 8'h70, 8'h80, 8'h81, 8'h03};
    wb_ready = 1'b0;
    drive(1'b1, 8'h05, 16'h1111, 5'b00001, 4'd4);
    @(negedge clk);
    wb_ready = 1'b1;
    drive(1'b1, 8'h09, 16'hFFFF, 5'b00110, 4'd5);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL pushpop_count got %0d exp 1", count); end
    checks++; if ({wb_addr, wb_data} !== {4'd5, 16'hFFFF}) begin errors++; $display("FAIL pushpop_head got %h exp 5ffff", {wb_addr, wb_data}); end
    @(negedge clk);
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL pushpop_drain got %0d exp 0", count); end
    while ((sent < 10 || got < 10) && cyc < 200) begin
      cyc++;
      checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL wrap_in_ready got %b exp %b", in_ready, q.size() < 2); end
      checks++; if (wb_valid !== (q.size() != 0)) begin errors++; $display("FAIL wrap_wb_valid got %b exp %b", wb_valid, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if ({wb_addr, wb_data} !== q[0]) begin errors++; $display("FAIL wrap_head got %h exp %h", {wb_addr, wb_data}, q[0]); end
      end
      full_pred = (q.size() == 2);
      wb_ready = 1'($urandom_range(0, 1));
      if (sent < 10) drive(1'b1, ops[sent], 16'h1000 + 16'(sent) * 16'h0101, 5'(sent), 4'(sent));
      else in_valid = 1'b0;
      if (q.size() != 0 && wb_ready) begin void'(q.pop_front()); got++; end
      if (in_valid && !full_pred) begin q.push_back({dest, alu_result}); sent++; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (got != 10) begin errors++; $display("FAIL wrap_completed got %0d exp 10", got); end
    checks++; if (psr !== 5'd9) begin errors++; $display("FAIL wrap_psr got %b exp 01001", psr); end
  endtask

  task automatic test_flush_reset();
    wb_ready = 1'b0;
    drive(1'b1, 8'h50, 16'h2222, 5'b00001, 4'd10);
    repeat (2) @(negedge clk);
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL flush_prefill got %0d exp 2", count); end
    flush = 1'b1;
    drive(1'b1, 8'h84, 16'h3333, 5'b10000, 4'd11);
    @(negedge clk);
    checks++; if ({count, wb_valid, in_ready} !== 4'b0001) begin errors++; $display("FAIL flush_full got %b exp 0001", {count, wb_valid, in_ready}); end
    checks++; if (psr !== 5'b00001) begin errors++; $display("FAIL flush_blocked_psr got %b exp 00001", psr); end
    @(negedge clk);
    flush = 1'b0;
    checks++; if (psr !== 5'b10000) begin errors++; $display("FAIL flush_accept_psr got %b exp 10000", psr); end
    checks++; if ({count, wb_valid} !== 3'b000) begin errors++; $display("FAIL flush_discard got %b exp 000", {count, wb_valid}); end
    drive(1'b1, 8'h06, 16'hBEEF, 5'b01100, 4'd9);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({count, wb_addr, wb_data} !== {2'd1, 4'd9, 16'hBEEF}) begin errors++; $display("FAIL refill_head got %h exp 19beef", {count, wb_addr, wb_data}); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({wb_valid, psr, count, in_ready} !== {1'b0, 5'b0, 2'd0, 1'b1}) begin errors++; $display("FAIL async_reset got %b exp 000000001", {wb_valid, psr, count, in_ready}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({wb_valid, count} !== 3'b000) begin errors++; $display("FAIL after_reset_empty got %b exp 000", {wb_valid, count}); end
  endtask

  initial begin
    test_reset();
    test_add_passthrough();
    test_cmp_nop();
    test_backpressure();
    test_back_to_back();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
